pelican_ctrl: RTL and testbench



---
 rtl/pelican_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pelican_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pelican_ctrl.sv
// Pedestrian-crossing (pelican) light controller: timed car/pedestrian phases with a latched request.
// Optional build macro PELICAN_FLASH_AMBER_EN selects flashing amber / flashing pedestrian green.
module pelican_ctrl #(
    parameter int T_GREEN_MIN = 8,
    parameter int T_YELLOW    = 3,
    parameter int T_CLEAR     = 2,
    parameter int T_WALK      = 6,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button,
    output logic       green_c,
    output logic       yellow_c,
    output logic       red_c,
    output logic       green_p,
    output logic       yellow_p,
    output logic       red_p,
    output logic       wait_p,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_CG  = 3'd0,
        S_CY  = 3'd1,
        S_PY1 = 3'd2,
        S_PG  = 3'd3,
        S_PY2 = 3'd4,
        S_CY2 = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_CLEAR  = CNT_W'(T_CLEAR - 1);
    localparam logic [CNT_W-1:0] LD_WALK   = CNT_W'(T_WALK - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CG;
            cnt_q   <= LD_GREEN;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    // Counter saturates at zero; each phase exit reloads it for the phase being entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? '0 : (cnt_q - CNT_ONE);
        case (state_q)
            S_CG: begin
                if (cnt_zero && req_q) begin
                    state_d = S_CY;
                    cnt_d   = LD_YELLOW;
                end
            end
            S_CY: begin
                if (cnt_zero) begin
                    state_d = S_PY1;
                    cnt_d   = LD_CLEAR;
                end
            end
            S_PY1: begin
                if (cnt_zero) begin
                    state_d = S_PG;
                    cnt_d   = LD_WALK;
                end
            end
            S_PG: begin
                if (cnt_zero) begin
                    state_d = S_PY2;
                    cnt_d   = LD_CLEAR;
                end
            end
            S_PY2: begin
                if (cnt_zero) begin
                    state_d = S_CY2;
                    cnt_d   = LD_YELLOW;
                end
            end
            S_CY2: begin
                if (cnt_zero) begin
                    state_d = S_CG;
                    cnt_d   = LD_GREEN;
                end
            end
            default: begin
                state_d = S_CG;
                cnt_d   = LD_GREEN;
            end
        endcase
    end

    // Presses during the walk phase belong to the request being served; clear beats set.
    always_comb begin
        req_d = req_q;
        if (button && (state_q != S_PG)) begin
            req_d = 1'b1;
        end
        if ((state_q == S_PY1) && cnt_zero) begin
            req_d = 1'b0;
        end
    end

    always_comb begin
        green_c  = 1'b0;
        yellow_c = 1'b0;
        red_c    = 1'b0;
        green_p  = 1'b0;
        yellow_p = 1'b0;
        red_p    = 1'b0;
        case (state_q)
            S_CG: begin
                green_c = 1'b1;
                red_p   = 1'b1;
            end
            S_CY: begin
                yellow_c = 1'b1;
                red_p    = 1'b1;
            end
            S_PY1: begin
                red_c    = 1'b1;
                yellow_p = 1'b1;
            end
            S_PG: begin
                red_c   = 1'b1;
                green_p = 1'b1;
            end
            S_PY2: begin
                red_c = 1'b1;
`ifdef PELICAN_FLASH_AMBER_EN
                green_p = cnt_q[0];
`else
                yellow_p = 1'b1;
`endif
            end
            S_CY2: begin
`ifdef PELICAN_FLASH_AMBER_EN
                yellow_c = cnt_q[0];
`else
                yellow_c = 1'b1;
`endif
                red_p = 1'b1;
            end
            default: begin
                green_c = 1'b1;
                red_p   = 1'b1;
            end
        endcase
    end

    assign wait_p  = req_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_pelican_ctrl.sv
// Directed bench for pelican_ctrl (default build): lamp/wait sequences checked cycle by cycle.
module tb_pelican_ctrl;

    logic       clk;
    logic       rst_n;
    logic       button;
    logic       green_c, yellow_c, red_c;
    logic       green_p, yellow_p, red_p;
    logic       wait_p;
    logic [2:0] state_o;

    int checks   = 0;
    int failures = 0;
    bit inv_on   = 1'b0;

    // Lamp patterns {green_c,yellow_c,red_c,green_p,yellow_p,red_p}
    localparam logic [5:0] L_CG  = 6'b100_001;
    localparam logic [5:0] L_CY  = 6'b010_001;
    localparam logic [5:0] L_PY  = 6'b001_010;
    localparam logic [5:0] L_PG  = 6'b001_100;

    pelican_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .button   (button),
        .green_c  (green_c),
        .yellow_c (yellow_c),
        .red_c    (red_c),
        .green_p  (green_p),
        .yellow_p (yellow_p),
        .red_p    (red_p),
        .wait_p   (wait_p),
        .state_o  (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (inv_on) begin
            checks++;
            assert ((32'(green_c) + 32'(yellow_c) + 32'(red_c) == 1) &&
                    (32'(green_p) + 32'(yellow_p) + 32'(red_p) == 1) &&
                    !(green_c && green_p))
            else begin
                failures++;
                $error("FAIL invariant obs=%b%b%b_%b%b%b exp=one-hot heads, no double green",
                       green_c, yellow_c, red_c, green_p, yellow_p, red_p);
            end
        end
    end

    task automatic chk(input string tag, input logic [5:0] lamps, input logic w);
        logic [6:0] obs;
        logic [6:0] exp;
        obs = {green_c, yellow_c, red_c, green_p, yellow_p, red_p, wait_p};
        exp = {lamps, w};
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s t=%0t obs=%b exp=%b", tag, $time, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Check the current cycle, then step past the next rising edge; repeated n times.
    task automatic expect_n(input string tag, input logic [5:0] lamps, input logic w, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, lamps, w);
            next_cycle();
        end
    endtask

    // Leaves the bench in cycle 0: reset released, first rising edge still ahead.
    task automatic do_reset(input logic btn_after);
        @(negedge clk);
        rst_n  = 1'b0;
        button = 1'b0;
        #1;
        chk("reset_asserted", L_CG, 1'b0);
        repeat (2) @(negedge clk);
        button = btn_after;
        rst_n  = 1'b1;
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        button = 1'b0;
        #2;
        inv_on = 1'b1;

        // Idle: no request, car green forever
        do_reset(1'b0);
        expect_n("idle_cg", L_CG, 1'b0, 50);

        // Single press in cycle 2
        do_reset(1'b0);
        expect_n("p1_cg_pre", L_CG, 1'b0, 2);
        button = 1'b1;
        expect_n("p1_cg_press", L_CG, 1'b0, 1);
        button = 1'b0;
        expect_n("p1_cg_wait", L_CG, 1'b1, 5);
        expect_n("p1_cy", L_CY, 1'b1, 3);
        expect_n("p1_py1", L_PY, 1'b1, 2);
        expect_n("p1_pg", L_PG, 1'b0, 6);
        expect_n("p1_py2", L_PY, 1'b0, 2);
        expect_n("p1_cy2", L_CY, 1'b0, 3);
        expect_n("p1_cg_after", L_CG, 1'b0, 10);

        // Button held: back-to-back crossings, request re-latched after walk
        do_reset(1'b1);
        expect_n("hold_cg0", L_CG, 1'b0, 1);
        expect_n("hold_cg", L_CG, 1'b1, 7);
        expect_n("hold_cy", L_CY, 1'b1, 3);
        expect_n("hold_py1", L_PY, 1'b1, 2);
        expect_n("hold_pg", L_PG, 1'b0, 6);
        expect_n("hold_py2_a", L_PY, 1'b0, 1);
        expect_n("hold_py2_b", L_PY, 1'b1, 1);
        expect_n("hold_cy2", L_CY, 1'b1, 3);
        expect_n("hold_cg2", L_CG, 1'b1, 8);
        expect_n("hold_cy_2nd", L_CY, 1'b1, 3);
        expect_n("hold_py1_2nd", L_PY, 1'b1, 2);
        expect_n("hold_pg_2nd", L_PG, 1'b0, 1);
        button = 1'b0;

        // Press in walk ignored, press in final amber served after minimum green
        do_reset(1'b0);
        expect_n("pp_cg_pre", L_CG, 1'b0, 2);
        button = 1'b1;
        expect_n("pp_cg_press", L_CG, 1'b0, 1);
        button = 1'b0;
        expect_n("pp_cg_wait", L_CG, 1'b1, 5);
        expect_n("pp_cy", L_CY, 1'b1, 3);
        expect_n("pp_py1", L_PY, 1'b1, 2);
        expect_n("pp_pg_a", L_PG, 1'b0, 1);
        button = 1'b1;
        expect_n("pp_pg_press", L_PG, 1'b0, 1);
        button = 1'b0;
        expect_n("pp_pg_b", L_PG, 1'b0, 4);
        expect_n("pp_py2", L_PY, 1'b0, 2);
        button = 1'b1;
        expect_n("pp_cy2_press", L_CY, 1'b0, 1);
        button = 1'b0;
        expect_n("pp_cy2_wait", L_CY, 1'b1, 2);
        expect_n("pp_cg_min", L_CG, 1'b1, 8);
        expect_n("pp_cy_2nd", L_CY, 1'b1, 3);
        expect_n("pp_py1_2nd", L_PY, 1'b1, 2);
        expect_n("pp_pg_2nd", L_PG, 1'b0, 1);

        // Asynchronous reset in the middle of the walk phase
        do_reset(1'b0);
        expect_n("ar_cg_pre", L_CG, 1'b0, 2);
        button = 1'b1;
        expect_n("ar_cg_press", L_CG, 1'b0, 1);
        button = 1'b0;
        expect_n("ar_cg_wait", L_CG, 1'b1, 5);
        expect_n("ar_cy", L_CY, 1'b1, 3);
        expect_n("ar_py1", L_PY, 1'b1, 2);
        expect_n("ar_pg", L_PG, 1'b0, 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_immediate", L_CG, 1'b0);
        @(negedge clk);
        chk("ar_held", L_CG, 1'b0);
        @(negedge clk);
        button = 1'b1;
        rst_n  = 1'b1;
        #1;
        expect_n("ar_cg0", L_CG, 1'b0, 1);
        expect_n("ar_cg_min", L_CG, 1'b1, 7);
        expect_n("ar_cy_after", L_CY, 1'b1, 1);
        button = 1'b0;

        inv_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
